seg7_multi_digit_driver: RTL
============================

// Module: seg7_multi_digit_driver
// PURPOSE
//  Parametrised multi-digit hex display driver for the board's 7-seg banks.
//  Latches a packed nibble word on a load strobe and drives NUM_DIGITS static digit buses.
//  Adds leading-zero blanking, per-digit blink and lamp test.
//  Sits between datapath status registers and the HEXn pins.
// PARAMETERS
//  NUM_DIGITS  6           digits driven; 1..8
//  ACTIVE_LOW  1           1: segment lit = 0 (board pins); 0: lit = 1
//  BLINK_DIV   25_000_000  clk cycles per blink half-period; >= 2
// PORTS
//  clk         in   1              system clock, all state on rising edge
//  rst_n       in   1              async active-low reset
//  load        in   1              strobe: capture value_in this edge
//  value_in    in   4*NUM_DIGITS   nibble k = digit k (digit 0 = LSBs)
//  blank_lz    in   1              level: enable leading-zero blanking
//  blink_mask  in   NUM_DIGITS     level: bit k = 1 blinks digit k
//  lamp_test   in   1              level: force every segment lit
//  seg_out     out  7*NUM_DIGITS   digit k at [7k+6:7k], format {g,f,e,d,c,b,a}
//  loaded      out  1              1-cycle pulse, cycle after a capture
// BEHAVIOUR
//  Clock and reset: one clock, clk.
//  - rst_n is asynchronous and active-low.
//  - Reset state: value_q=0, valid_q=0, blink_cnt=0, blink_phase=0, loaded=0.
//  - seg_out = all segments dark at reset (all 1s when ACTIVE_LOW=1).
//  Load:
//  - load=1 at edge N: value_q <= value_in, valid_q <= 1.
//  - seg_out shows the new value from edge N+1. seg_out is registered, so latency is 1 cycle.
//  - loaded pulses high for the cycle after edge N.
//  - Back-to-back loads are legal; the last one wins. There is no busy state.
//  Blink timer:
//  - blink_cnt counts 0..BLINK_DIV-1 and wraps to 0.
//  - On wrap, blink_phase toggles.
//  - Free-running from reset. Unaffected by load or by any mask change.
//  Leading-zero blanking:
//  - Digit k is blanked when blank_lz=1, nibble k=0, and every nibble above k is 0.
//  - Digit 0 is never LZ-blanked, so value 0 shows a single "0".
//  Per-digit priority, highest first:
//  - lamp_test: all 7 segments lit.
//  - !valid_q: dark.
//  - blink_mask[k] && blink_phase: dark.
//  - LZ-blanked: dark.
//  - otherwise: glyph(nibble k).
//  Glyph table, {g..a} lit=1 hex:
//  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//  - 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
//  - ACTIVE_LOW=1 inverts the final 7 bits per digit after priority. Dark = 7'h7F on pins.
//  Level inputs (blank_lz, blink_mask, lamp_test):
//  - Sampled every cycle.
//  - Change is visible on seg_out exactly 1 cycle later.
//  Reset mid-operation:
//  - Returns to reset state immediately and asynchronously.
//  - Display goes dark until the next load.
// STRUCTURE
//  Shared package seg7_pkg:
//  - 16-entry glyph constant table.
//  - SEG_DARK / SEG_ALL constants in lit=1 form.
//  - seg_t 7-bit type.
//  Sub-module seg7_glyph (combinational nibble -> lit=1 pattern):
//  - one instance per digit via generate.
//  Top level holds value_q, valid_q, blink counter, LZ prefix chain, output register.
// TESTING
//  1. Reset, NUM_DIGITS=6, ACTIVE_LOW=1
//     -> seg_out = 42'h3FF_FFFF_FFFF, loaded=0, until first load.
//  2. load value_in=24'h0000A5, blank_lz=1
//     -> cycle after: digit0=~6D, digit1=~77, digits2..5=7F.
//     -> loaded=1 for exactly 1 cycle.
//  3. load 24'h000000 with blank_lz=1 -> digit0=~3F, others dark.
//     Then blank_lz=0 -> next cycle all six show ~3F.
//  4. BLINK_DIV=4, blink_mask=6'b000001, value 24'h123456
//     -> digit0 alternates ~7D / dark every 4 cycles.
//     -> other digits steady. A load mid-phase does not shift the blink boundary.
//  5. lamp_test=1 while not valid and while blinking
//     -> all digits 7'h00 (all lit) the next cycle. Release restores prior display.
//  6. Assert rst_n low mid-blink after a load
//     -> immediate dark outputs, loaded=0, blink_cnt restarts from 0 on release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit 7-segment driver.
// Segment patterns are held in lit=1 form {g,f,e,d,c,b,a}; pin polarity is applied last.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DARK = 7'h00;
    localparam seg_t SEG_ALL  = 7'h7F;

    localparam seg_t GLYPH_TBL [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Board pins are lit-low when active_low is set.
    function automatic seg_t to_pins(input seg_t lit, input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg7_multi_digit_driver_if.sv
// Display bus between the status datapath (master) and the 7-seg driver (slave).
interface seg7_multi_digit_driver_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lamp_test;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic                    loaded;

    modport master (
        output load, value_in, blank_lz, blink_mask, lamp_test,
        input  seg_out, loaded
    );

    modport slave (
        input  load, value_in, blank_lz, blink_mask, lamp_test,
        output seg_out, loaded
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to lit=1 segment pattern.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);
    assign seg_o = GLYPH_TBL[nibble_i];
endmodule

// File: rtl/seg7_multi_digit_driver.sv
// Multi-digit hex display driver: latched value, leading-zero blanking,
// per-digit blink, lamp test, registered static segment outputs.
module seg7_multi_digit_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seg7_multi_digit_driver_if.slave    bus
);
    localparam int   CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic POL_LOW  = (ACTIVE_LOW != 0);
    localparam seg_t DARK_PIN = to_pins(SEG_DARK, POL_LOW);

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    valid_q, valid_d;
    logic [CNT_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    loaded_q, loaded_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

    // zero_from[k]: nibble k and every nibble above it are zero.
    logic [NUM_DIGITS:0]     zero_from;

    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] & (value_q[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        value_d       = bus.load ? bus.value_in : value_q;
        valid_d       = valid_q | bus.load;
        loaded_d      = bus.load;
        blink_cnt_d   = blink_cnt_q + CNT_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam logic LZ_ALLOWED = (k != 0);
        seg_t glyph;
        seg_t lit;

        seg7_glyph u_glyph (
            .nibble_i (value_q[4*k +: 4]),
            .seg_o    (glyph)
        );

        // Priority: lamp test > not loaded > blink > leading-zero > glyph.
        always_comb begin
            if (bus.lamp_test) begin
                lit = SEG_ALL;
            end else if (!valid_q) begin
                lit = SEG_DARK;
            end else if (bus.blink_mask[k] && blink_phase_q) begin
                lit = SEG_DARK;
            end else if (LZ_ALLOWED && bus.blank_lz && zero_from[k]) begin
                lit = SEG_DARK;
            end else begin
                lit = glyph;
            end
        end

        assign seg_d[7*k +: 7] = to_pins(lit, POL_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q       <= '0;
            valid_q       <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            loaded_q      <= 1'b0;
            seg_q         <= {NUM_DIGITS{DARK_PIN}};
        end else begin
            value_q       <= value_d;
            valid_q       <= valid_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            loaded_q      <= loaded_d;
            seg_q         <= seg_d;
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.loaded  = loaded_q;

endmodule
